dbg_run_ctrl: RTL and testbench
===============================

Name: dbg_run_ctrl

Overview:
- Multi-hart run-control core in the sys_clk domain. It is the parametrised successor of the single-core halt/step/resume debug FSM.
- Inputs are single-cycle request strobes, already synchronised from the TCK domain. A hart-select mask picks which harts each request applies to.
- Adds multi-cycle stepping (N cycles per step), external breakpoint halts, a per-hart halted/step-done status, and a configurable reset state.
- Outputs are per-hart registered clock-enables. These drive glitch-free clock-gate cells that live outside this block.

Parameters:
NUM_HARTS, 4, number of independently controlled harts (1..32)
STEP_W, 8, width of the step cycle counter
HALT_ON_RESET, 0, 1 = all harts come out of reset halted, 0 = all harts come out of reset running

Ports:
sys_clk  in  1  system clock; everything is sampled on the rising edge
dbg_rst  in  1  reset, synchronous, active-low
halt_req  in  1  one-cycle strobe: halt the selected harts
step_req  in  1  one-cycle strobe: step the selected harts
resume_req  in  1  one-cycle strobe: resume the selected harts
hart_sel  in  NUM_HARTS  target mask; sampled only in a cycle where a request strobe is high
step_count  in  STEP_W  number of enabled cycles per step; sampled together with step_req; 0 is treated as 1
ext_halt  in  NUM_HARTS  per-hart breakpoint/trigger halt; level, sampled every cycle
clk_en  out  NUM_HARTS  registered clock-enable per hart
halted  out  NUM_HARTS  1 when the hart is in the HALT state
step_done  out  NUM_HARTS  one-cycle pulse when a hart's step completes normally
busy  out  1  OR over all harts of (state == STEP)

Behaviour:
- One independent FSM per hart, with states RUN, HALT, STEP. All outputs are registered or decoded directly from registered state (Moore).
- Reset (dbg_rst == 0 at a rising edge):
  - HALT_ON_RESET = 0: state = RUN, clk_en = 1, halted = 0.
  - HALT_ON_RESET = 1: state = HALT, clk_en = 0, halted = 1.
  - In both cases: step counter = 0, step_done = 0, busy = 0.
  - Reset mid-step aborts the step with no step_done pulse.
- A request affects hart i only if hart_sel[i] = 1 in the same cycle.
- Effective request priority when strobes coincide: ext_halt[i] / halt_req > step_req > resume_req.
- RUN:
  - halt_req or ext_halt[i] -> HALT.
  - step_req and resume_req are ignored.
- HALT:
  - step_req -> STEP, with counter = max(step_count, 1).
  - resume_req -> RUN.
  - halt_req is ignored.
  - ext_halt[i] held high does not block step or resume. Its re-halt takes effect one cycle after the hart leaves HALT, so at least one enabled cycle always occurs.
- STEP:
  - Counter decrements every cycle.
  - In the cycle where counter == 1 and no abort is pending: next state is HALT, and step_done[i] pulses in the first HALT cycle.
  - halt_req or ext_halt[i] aborts the step: next state is HALT, no step_done, counter cleared.
  - step_req and resume_req are ignored; a step never restarts mid-step.
- clk_en[i] = 1 in RUN and STEP, 0 in HALT.
- Step latency: step_req at edge t, with count N, gives clk_en high for exactly N cycles (t+1..t+N). Then halted = 1 and step_done = 1 at t+N+1.
- Halt latency: request at edge t gives clk_en = 0 and halted = 1 at t+1.
- Resume latency: request at edge t gives clk_en = 1 at t+1.
- Counter arithmetic: unsigned STEP_W bits, loads 1..2^STEP_W-1, never wraps below 0. step_count = all-ones yields 2^STEP_W-1 cycles.
- Harts never interact. A mixed mask applies the request only to harts whose current state accepts it; the other harts are unchanged.

Decomposition:
- Package dbg_pkg holds:
  - typedef enum logic [1:0] dbg_state_t: DBG_RUN = 2'b00, DBG_HALT = 2'b01, DBG_STEP = 2'b10.
  - The priority encoding constants.
- Sub-module dbg_hart_ctrl:
  - Contains one hart's FSM, counter and outputs; parameters STEP_W and HALT_ON_RESET.
  - Instantiated NUM_HARTS times in a generate loop.
- The top level only fans out the strobes ANDed with hart_sel[i], and ORs the per-hart STEP flags into busy.

Test Plan:
- Reset with HALT_ON_RESET = 0, NUM_HARTS = 4 -> clk_en = 4'b1111, halted = 0, busy = 0; with HALT_ON_RESET = 1 -> clk_en = 4'b0000, halted = 4'b1111.
- halt_req with hart_sel = 4'b0101 -> next cycle clk_en = 4'b1010, halted = 4'b0101; then resume_req with 4'b0001 -> clk_en = 4'b1011.
- All harts halted; step_req with hart_sel = 4'b0010, step_count = 5 -> clk_en[1] high for exactly 5 cycles, busy high for those 5 cycles, then step_done = 4'b0010 for 1 cycle and halted[1] = 1. Repeat with step_count = 0 -> exactly 1 enabled cycle.
- Hart 2 stepping with step_count = 10; ext_halt[2] pulses at step cycle 3 -> clk_en[2] = 0 on the next cycle, no step_done, halted[2] = 1, busy = 0.
- halt_req, step_req and resume_req in the same cycle with hart_sel = 4'b1111, all harts running -> all halted; repeat with all harts halted -> all harts step (step wins over resume).
- dbg_rst asserted during a 200-cycle step with STEP_W = 8 -> next cycle reset values, no step_done; also check step_count = 255 gives exactly 255 enabled cycles.

Source files
------------

// File: rtl/dbg_pkg.sv
// rtl/dbg_pkg.sv - shared types and request priority for multi-hart run control
package dbg_pkg;

  typedef enum logic [1:0] {
    DBG_RUN  = 2'b00,
    DBG_HALT = 2'b01,
    DBG_STEP = 2'b10
  } dbg_state_t;

  // Effective request after priority resolution: halt beats step beats resume.
  typedef enum logic [1:0] {
    REQ_NONE   = 2'b00,
    REQ_HALT   = 2'b01,
    REQ_STEP   = 2'b10,
    REQ_RESUME = 2'b11
  } dbg_req_t;

  function automatic dbg_req_t pick_req(input logic halt, input logic step, input logic resume);
    if (halt)        return REQ_HALT;
    else if (step)   return REQ_STEP;
    else if (resume) return REQ_RESUME;
    else             return REQ_NONE;
  endfunction

endpackage

// File: rtl/dbg_hart_ctrl.sv
// rtl/dbg_hart_ctrl.sv - one hart's run/halt/step FSM with step counter
module dbg_hart_ctrl
  import dbg_pkg::*;
#(
  parameter int STEP_W        = 8,
  parameter bit HALT_ON_RESET = 1'b0
) (
  input  logic              sys_clk,
  input  logic              dbg_rst,
  input  logic              halt,
  input  logic              step,
  input  logic              resume,
  input  logic              ext_halt,
  input  logic [STEP_W-1:0] step_count,
  output logic              clk_en,
  output logic              halted,
  output logic              step_done,
  output logic              stepping
);

  localparam dbg_state_t RESET_STATE = HALT_ON_RESET ? DBG_HALT : DBG_RUN;

  dbg_state_t        state, state_next;
  logic [STEP_W-1:0] cnt, cnt_next;
  logic              done_next;
  logic              any_halt;

  assign any_halt = halt | ext_halt;

  always_ff @(posedge sys_clk) begin
    if (!dbg_rst) begin
      state     <= RESET_STATE;
      cnt       <= '0;
      step_done <= 1'b0;
      clk_en    <= !HALT_ON_RESET;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      step_done <= done_next;
      clk_en    <= (state_next != DBG_HALT);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done_next  = 1'b0;
    unique case (state)
      DBG_RUN: begin
        if (any_halt) state_next = DBG_HALT;
      end
      DBG_HALT: begin
        // Halt sources are meaningless here; ext_halt re-halts only after leaving.
        unique case (pick_req(1'b0, step, resume))
          REQ_STEP: begin
            state_next = DBG_STEP;
            cnt_next   = (step_count == '0) ? STEP_W'(1) : step_count;
          end
          REQ_RESUME: state_next = DBG_RUN;
          default:    state_next = DBG_HALT;
        endcase
      end
      DBG_STEP: begin
        if (any_halt) begin
          state_next = DBG_HALT;
          cnt_next   = '0;
        end else if (cnt <= STEP_W'(1)) begin
          state_next = DBG_HALT;
          cnt_next   = '0;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt - STEP_W'(1);
        end
      end
      default: begin
        state_next = RESET_STATE;
        cnt_next   = '0;
      end
    endcase
  end

  assign halted   = (state == DBG_HALT);
  assign stepping = (state == DBG_STEP);

endmodule

// File: rtl/dbg_run_ctrl.sv
// rtl/dbg_run_ctrl.sv - multi-hart run control: per-hart request fan-out and busy reduction
module dbg_run_ctrl
  import dbg_pkg::*;
#(
  parameter int NUM_HARTS     = 4,
  parameter int STEP_W        = 8,
  parameter bit HALT_ON_RESET = 1'b0
) (
  input  logic                 sys_clk,
  input  logic                 dbg_rst,
  input  logic                 halt_req,
  input  logic                 step_req,
  input  logic                 resume_req,
  input  logic [NUM_HARTS-1:0] hart_sel,
  input  logic [STEP_W-1:0]    step_count,
  input  logic [NUM_HARTS-1:0] ext_halt,
  output logic [NUM_HARTS-1:0] clk_en,
  output logic [NUM_HARTS-1:0] halted,
  output logic [NUM_HARTS-1:0] step_done,
  output logic                 busy
);

  logic [NUM_HARTS-1:0] stepping;

  for (genvar i = 0; i < NUM_HARTS; i++) begin : g_hart
    dbg_hart_ctrl #(
      .STEP_W        (STEP_W),
      .HALT_ON_RESET (HALT_ON_RESET)
    ) u_hart (
      .sys_clk    (sys_clk),
      .dbg_rst    (dbg_rst),
      .halt       (halt_req & hart_sel[i]),
      .step       (step_req & hart_sel[i]),
      .resume     (resume_req & hart_sel[i]),
      .ext_halt   (ext_halt[i]),
      .step_count (step_count),
      .clk_en     (clk_en[i]),
      .halted     (halted[i]),
      .step_done  (step_done[i]),
      .stepping   (stepping[i])
    );
  end

  assign busy = |stepping;

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// tb/tb_dbg_run_ctrl.sv - directed self-checking bench for dbg_run_ctrl
module tb_dbg_run_ctrl;

  logic       sys_clk = 1'b0;
  logic       dbg_rst;
  logic       halt_req, step_req, resume_req;
  logic [3:0] hart_sel, ext_halt;
  logic [7:0] step_count;
  logic [3:0] clk_en, halted, step_done;
  logic       busy;
  logic [3:0] clk_en_h, halted_h, step_done_h;
  logic       busy_h;

  int vecs = 0;
  int errs = 0;
  int n;

  always #5 sys_clk = ~sys_clk;

  dbg_run_ctrl #(.NUM_HARTS(4), .STEP_W(8), .HALT_ON_RESET(1'b0)) dut (
    .sys_clk(sys_clk), .dbg_rst(dbg_rst), .halt_req(halt_req), .step_req(step_req),
    .resume_req(resume_req), .hart_sel(hart_sel), .step_count(step_count), .ext_halt(ext_halt),
    .clk_en(clk_en), .halted(halted), .step_done(step_done), .busy(busy)
  );

  dbg_run_ctrl #(.NUM_HARTS(4), .STEP_W(8), .HALT_ON_RESET(1'b1)) dut_h (
    .sys_clk(sys_clk), .dbg_rst(dbg_rst), .halt_req(halt_req), .step_req(step_req),
    .resume_req(resume_req), .hart_sel(hart_sel), .step_count(step_count), .ext_halt(ext_halt),
    .clk_en(clk_en_h), .halted(halted_h), .step_done(step_done_h), .busy(busy_h)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic h, input logic s, input logic r, input logic [3:0] sel);
    halt_req = h; step_req = s; resume_req = r; hart_sel = sel;
    tick();
    halt_req = 1'b0; step_req = 1'b0; resume_req = 1'b0; hart_sel = 4'b0000;
  endtask

  // Counts consecutive enabled cycles of hart h, starting at the current cycle.
  task automatic measure(input int h, output int cnt);
    cnt = 0;
    while (clk_en[h] && cnt < 1000) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    dbg_rst = 1'b0; halt_req = 1'b0; step_req = 1'b0; resume_req = 1'b0;
    hart_sel = 4'b0000; ext_halt = 4'b0000; step_count = 8'd0;
    tick(); tick();
    chk("rst_clk_en", clk_en, 4'b1111);
    chk("rst_halted", halted, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_step_done", step_done, 4'b0000);
    chk("rst_h_clk_en", clk_en_h, 4'b0000);
    chk("rst_h_halted", halted_h, 4'b1111);
    dbg_rst = 1'b1;
    tick();

    strobe(1'b1, 1'b0, 1'b0, 4'b0101);
    chk("halt_mask_clk_en", clk_en, 4'b1010);
    chk("halt_mask_halted", halted, 4'b0101);
    strobe(1'b0, 1'b0, 1'b1, 4'b0001);
    chk("resume0_clk_en", clk_en, 4'b1011);
    chk("resume0_halted", halted, 4'b0100);
    strobe(1'b1, 1'b0, 1'b0, 4'b1111);
    chk("halt_all_clk_en", clk_en, 4'b0000);

    step_count = 8'd5;
    strobe(1'b0, 1'b1, 1'b0, 4'b0010);
    chk("step5_first_clk_en", clk_en, 4'b0010);
    chk("step5_busy", busy, 1'b1);
    measure(1, n);
    chk("step5_cycles", n, 5);
    chk("step5_done", step_done, 4'b0010);
    chk("step5_halted", halted, 4'b1111);
    chk("step5_busy_end", busy, 1'b0);
    tick();
    chk("step5_done_pulse", step_done, 4'b0000);

    step_count = 8'd0;
    strobe(1'b0, 1'b1, 1'b0, 4'b0010);
    measure(1, n);
    chk("step0_cycles", n, 1);
    chk("step0_done", step_done, 4'b0010);

    step_count = 8'd10;
    strobe(1'b0, 1'b1, 1'b0, 4'b0100);
    tick(); tick();
    chk("abort_still_step", clk_en, 4'b0100);
    ext_halt = 4'b0100;
    tick();
    ext_halt = 4'b0000;
    chk("abort_clk_en", clk_en, 4'b0000);
    chk("abort_halted", halted, 4'b1111);
    chk("abort_busy", busy, 1'b0);
    chk("abort_no_done", step_done, 4'b0000);
    tick();
    chk("abort_no_done_late", step_done, 4'b0000);

    strobe(1'b0, 1'b0, 1'b1, 4'b1111);
    chk("resume_all", clk_en, 4'b1111);
    strobe(1'b1, 1'b1, 1'b1, 4'b1111);
    chk("all3_running_halted", halted, 4'b1111);
    chk("all3_running_clk_en", clk_en, 4'b0000);
    step_count = 8'd3;
    strobe(1'b1, 1'b1, 1'b1, 4'b1111);
    chk("all3_halted_step_clk_en", clk_en, 4'b1111);
    chk("all3_halted_step_busy", busy, 1'b1);
    tick(); tick();
    chk("all3_step_third", clk_en, 4'b1111);
    tick();
    chk("all3_step_done", step_done, 4'b1111);
    chk("all3_step_halted", halted, 4'b1111);

    ext_halt = 4'b0001;
    strobe(1'b0, 1'b0, 1'b1, 4'b0001);
    chk("ext_resume_one_cycle", clk_en, 4'b0001);
    tick();
    chk("ext_rehalt", halted, 4'b1111);
    ext_halt = 4'b0000;

    step_count = 8'd255;
    strobe(1'b0, 1'b1, 1'b0, 4'b1000);
    measure(3, n);
    chk("step255_cycles", n, 255);
    chk("step255_done", step_done, 4'b1000);

    step_count = 8'd200;
    strobe(1'b0, 1'b1, 1'b0, 4'b0001);
    for (int i = 0; i < 50; i++) tick();
    chk("midstep_busy", busy, 1'b1);
    dbg_rst = 1'b0;
    tick();
    dbg_rst = 1'b1;
    chk("midrst_clk_en", clk_en, 4'b1111);
    chk("midrst_halted", halted, 4'b0000);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_step_done", step_done, 4'b0000);
    chk("midrst_h_halted", halted_h, 4'b1111);
    tick();
    chk("midrst_no_done_late", step_done, 4'b0000);
    chk("midrst_run", clk_en, 4'b1111);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
